cfg_loader: RTL

Configuration loader for connection-box (CB) configuration chains. Accepts a word-wide bitstream over a valid/ready handshake and serialises it, MSB first, into the two CB shift chains (A and B) in lockstep. Drives the chain enable, holds the fabric enable low while configuration is in progress, and reports busy, done and abort status. Sits between the bitstream source (host or boot ROM) and the `config_data_inA/B` / `config_en` pins of one CB chain segment.

---
 rtl/cfg_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//
// Loads the two connection-box configuration chains (A and B) in lockstep from
// a word-wide bitstream. Each lane has a WORD_W shifter and a one-entry
// prefetch buffer. Both lanes share one set of control. Bits leave MSB first,
// and only the first CHAIN_LEN bits of the stream are used.
//
// Handshake: a word moves from the source into the loader on a rising edge
// where word_valid && word_ready are both high. word_ready is decoded from
// registered state only. It is high in LOAD while the prefetch buffer is
// empty and fewer than NWORDS words have been taken.
//
// Ports
//   clk, nrst               clock, synchronous active-low reset
//   start, abort            begin a load (IDLE/DONE) / cancel a load (LOAD)
//   word_dataA/B            next bitstream word per lane
//   word_valid, word_ready  bitstream handshake
//   chain_en, chain_dinA/B  CB config_en / config_data_inA/B
//   fabric_en               CB en; high only after a complete load
//   busy, done, err         LOAD / DONE / sticky abort flag
//   dbg_state               FSM state (0 = IDLE, 1 = LOAD, 2 = DONE)
// -----------------------------------------------------------------------------
module cfg_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_dataA,
  input  logic [WORD_W-1:0] word_dataB,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_en,
  output logic              chain_dinA,
  output logic              chain_dinB,
  output logic              fabric_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BCW    = $clog2(CHAIN_LEN + 1);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int SCW    = $clog2(WORD_W + 1);

  localparam logic [BCW-1:0] LP_CHAIN_LEN = BCW'(CHAIN_LEN);
  localparam logic [WCW-1:0] LP_NWORDS    = WCW'(NWORDS);
  localparam logic [SCW-1:0] LP_REFILL    = SCW'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BCW-1:0]    r_bit_cnt;    // bits presented on the chain so far
  logic [WCW-1:0]    r_word_cnt;   // words accepted in this load
  logic [SCW-1:0]    r_shift_cnt;  // bits still waiting in the shifters
  logic [WORD_W-1:0] r_shA;
  logic [WORD_W-1:0] r_shB;
  logic [WORD_W-1:0] r_bufA;
  logic [WORD_W-1:0] r_bufB;
  logic              r_buf_full;
  logic              r_chain_en;
  logic              r_dinA;
  logic              r_dinB;
  logic              r_fabric_en;
  logic              r_err;
  logic              r_busy;
  logic              r_done;

  logic w_start_acc;
  logic w_abort;
  logic w_bits_done;
  logic w_shift_has;
  logic w_present;
  logic w_xfer;

  assign w_start_acc = start && (r_state != S_LOAD);
  assign w_abort     = abort && (r_state == S_LOAD);
  assign w_bits_done = (r_bit_cnt == LP_CHAIN_LEN);
  assign w_shift_has = (r_shift_cnt != '0);
  // A bit goes out whenever one is available and the chain is not yet full.
  // When both the shifter and the buffer are empty, the chain stalls. The bit
  // counter then holds, so no bit is lost or duplicated.
  assign w_present   = (r_state == S_LOAD) && !abort && !w_bits_done &&
                       (w_shift_has || r_buf_full);
  assign word_ready  = (r_state == S_LOAD) && !r_buf_full && (r_word_cnt < LP_NWORDS);
  assign w_xfer      = word_valid && word_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (abort)            w_next = S_IDLE;
        else if (w_bits_done) w_next = S_DONE;
      end
      S_DONE:  if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_shift_cnt <= '0;
      r_shA       <= '0;
      r_shB       <= '0;
      r_bufA      <= '0;
      r_bufB      <= '0;
      r_buf_full  <= 1'b0;
      r_chain_en  <= 1'b0;
      r_dinA      <= 1'b0;
      r_dinB      <= 1'b0;
      r_fabric_en <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_next == S_LOAD);
      r_done <= (w_next == S_DONE);
      if (w_start_acc) begin
        r_bit_cnt   <= '0;
        r_word_cnt  <= '0;
        r_shift_cnt <= '0;
        r_buf_full  <= 1'b0;
        r_chain_en  <= 1'b0;
        r_fabric_en <= 1'b0;
        r_err       <= 1'b0;
      end else if (w_abort) begin
        // The CB keeps whatever partial chain it already holds.
        r_chain_en  <= 1'b0;
        r_shift_cnt <= '0;
        r_buf_full  <= 1'b0;
        r_err       <= 1'b1;
      end else if (r_state == S_LOAD) begin
        r_chain_en <= w_present;
        if (w_present) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_shift_has) begin
            r_dinA      <= r_shA[WORD_W-1];
            r_dinB      <= r_shB[WORD_W-1];
            r_shA       <= r_shA << 1;
            r_shB       <= r_shB << 1;
            r_shift_cnt <= r_shift_cnt - 1'b1;
          end else begin
            // The shifter is empty, so its next MSB comes straight from the buffer.
            r_dinA      <= r_bufA[WORD_W-1];
            r_dinB      <= r_bufB[WORD_W-1];
            r_shA       <= r_bufA << 1;
            r_shB       <= r_bufB << 1;
            r_shift_cnt <= LP_REFILL;
          end
        end
        // Fill and drain are exclusive: a fill needs an empty buffer, and a
        // drain needs a full one.
        if (w_xfer) begin
          r_bufA     <= word_dataA;
          r_bufB     <= word_dataB;
          r_buf_full <= 1'b1;
          r_word_cnt <= r_word_cnt + 1'b1;
        end else if (w_present && !w_shift_has) begin
          r_buf_full <= 1'b0;
        end
        if (w_bits_done) r_fabric_en <= 1'b1;
      end
    end
  end

  assign chain_en   = r_chain_en;
  assign chain_dinA = r_dinA;
  assign chain_dinB = r_dinB;
  assign fabric_en  = r_fabric_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule
